// File: rtl/y86_pkg.sv
// Shared encodings and FSM state type for the Y86-64 pipeline control slice.
package y86_pkg;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } ctrl_state_e;

  // Instructions whose result arrives from data memory (load/use candidates).
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Stall/bubble generator for the 5-stage Y86-64 pipeline, with data-memory wait
// sequencing, a terminal halted state and saturating stall/bubble counters.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       W_stat_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             W_bubble_o,
  output logic             set_cc_o,
  output logic             dmem_timeout_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam int WAIT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT);

  ctrl_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              lu, rt, mp, exc_m, exc_w;
  logic              dmem_enter, timeout_hit;
  logic              stall_en, bubble_en;

  assign lu = is_load(E_icode_i) && (E_dstM_i != REG_NONE) &&
              ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign rt    = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
  assign mp    = (E_icode_i == I_JXX) && !e_Cnd_i;
  assign exc_m = (m_stat_i != S_AOK);
  assign exc_w = (W_stat_i != S_AOK);

  // Data memory handshake: dmem_req_i marks an access presented by the Memory
  // stage; it completes in any cycle where dmem_ready_i is high. A request that
  // is not ready in its first cycle freezes F/D/M until ready or timeout.
  assign dmem_enter  = dmem_req_i && !dmem_ready_i && !exc_m && !exc_w;
  assign wait_inc    = wait_cnt + 1'b1;
  assign timeout_hit = (DMEM_TIMEOUT != 0) && !dmem_ready_i && (wait_inc == WAIT_LAST);

  always_comb begin
    F_stall_o      = 1'b0;
    D_stall_o      = 1'b0;
    D_bubble_o     = 1'b0;
    E_bubble_o     = 1'b0;
    M_bubble_o     = 1'b0;
    W_stall_o      = 1'b0;
    W_bubble_o     = 1'b0;
    set_cc_o       = 1'b0;
    dmem_timeout_o = 1'b0;
    halted_o       = 1'b0;
    case (state)
      ST_RUN: begin
        if (dmem_enter) begin
          // M is held by the upstream stall chain while W receives bubbles.
          F_stall_o  = 1'b1;
          D_stall_o  = 1'b1;
          E_bubble_o = 1'b1;
          W_bubble_o = 1'b1;
          set_cc_o   = (E_icode_i == I_OPQ);
        end else begin
          F_stall_o  = lu || rt || !imem_ready_i;
          D_stall_o  = lu;
          D_bubble_o = mp || (rt && !lu) || (!imem_ready_i && !lu && !mp);
          E_bubble_o = mp || lu;
          M_bubble_o = exc_m || exc_w;
          W_stall_o  = exc_w;
          set_cc_o   = (E_icode_i == I_OPQ) && !exc_m && !exc_w;
        end
      end
      ST_DMEM_WAIT: begin
        F_stall_o      = 1'b1;
        D_stall_o      = 1'b1;
        W_bubble_o     = 1'b1;
        dmem_timeout_o = timeout_hit;
      end
      ST_HALTED: begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        W_stall_o = 1'b1;
        halted_o  = 1'b1;
      end
      default: ;
    endcase
    if (rst_i) begin
      F_stall_o      = 1'b0;
      D_stall_o      = 1'b0;
      D_bubble_o     = 1'b0;
      E_bubble_o     = 1'b0;
      M_bubble_o     = 1'b0;
      W_stall_o      = 1'b0;
      W_bubble_o     = 1'b0;
      set_cc_o       = 1'b0;
      dmem_timeout_o = 1'b0;
      halted_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_w) begin
            state <= ST_HALTED;
          end else if (dmem_enter) begin
            state    <= ST_DMEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_DMEM_WAIT: begin
          // A timeout returns to RUN; the Memory stage then reports ADR itself.
          if (dmem_ready_i || timeout_hit) begin
            state <= ST_RUN;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign dbg_state_o = state;

  assign stall_en  = F_stall_o && (state != ST_HALTED);
  assign bubble_en = (D_bubble_o || E_bubble_o) && (state != ST_HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt_o)
  );

endmodule
